// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decoded instruction fields in, registered ALU
// operands and downstream controls out.
interface id_ex_if #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
);
  logic               id_valid;
  logic               stall;
  logic               flush;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [WIDTH-1:0]   rs_data;
  logic [WIDTH-1:0]   rt_data;
  logic [15:0]        imm;
  logic [REGBITS-1:0] rt;
  logic [REGBITS-1:0] rd;

  logic               ex_valid;
  logic [3:0]         alu_control;
  logic [WIDTH-1:0]   alu_in1;
  logic [WIDTH-1:0]   alu_in2;
  logic [WIDTH-1:0]   store_data;
  logic [REGBITS-1:0] dest_reg;
  logic               reg_write;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               branch;
  logic               illegal;

  modport master (
    output id_valid, stall, flush, opcode, funct, rs_data, rt_data, imm, rt, rd,
    input  ex_valid, alu_control, alu_in1, alu_in2, store_data, dest_reg,
           reg_write, mem_read, mem_write, mem_to_reg, branch, illegal
  );

  modport slave (
    input  id_valid, stall, flush, opcode, funct, rs_data, rt_data, imm, rt, rd,
    output ex_valid, alu_control, alu_in1, alu_in2, store_data, dest_reg,
           reg_write, mem_read, mem_write, mem_to_reg, branch, illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes opcode/funct into ALU control and
// downstream controls, with stall hold, flush bubble and illegal detect.
module id_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input logic   clock,
  input logic   reset,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic               ex_valid;
    logic [3:0]         alu_control;
    logic [WIDTH-1:0]   alu_in1;
    logic [WIDTH-1:0]   alu_in2;
    logic [WIDTH-1:0]   store_data;
    logic [REGBITS-1:0] dest_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               branch;
  } ex_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  ex_t              q, nxt;
  logic             ill_q, nxt_ill, legal;
  logic [WIDTH-1:0] sext;

  assign sext = {{(WIDTH-16){bus.imm[15]}}, bus.imm};

  always_comb begin
    nxt             = '0;
    legal           = 1'b1;
    nxt.ex_valid    = 1'b1;
    nxt.alu_in1     = bus.rs_data;
    nxt.store_data  = bus.rt_data;
    case (bus.opcode)
      6'b000000: begin
        nxt.alu_in2   = bus.rt_data;
        nxt.dest_reg  = bus.rd;
        nxt.reg_write = 1'b1;
        case (bus.funct)
          6'b100000, 6'b100001: nxt.alu_control = ALU_ADD;
          6'b100010, 6'b100011: nxt.alu_control = ALU_SUB;
          6'b101010:            nxt.alu_control = ALU_SLT;
          default:              legal = 1'b0;
        endcase
      end
      6'b100011: begin
        nxt.alu_control = ALU_ADD;
        nxt.alu_in2     = sext;
        nxt.dest_reg    = bus.rt;
        nxt.reg_write   = 1'b1;
        nxt.mem_read    = 1'b1;
        nxt.mem_to_reg  = 1'b1;
      end
      6'b101011: begin
        nxt.alu_control = ALU_ADD;
        nxt.alu_in2     = sext;
        nxt.mem_write   = 1'b1;
      end
      6'b001000: begin
        nxt.alu_control = ALU_ADD;
        nxt.alu_in2     = sext;
        nxt.dest_reg    = bus.rt;
        nxt.reg_write   = 1'b1;
      end
      6'b001010: begin
        nxt.alu_control = ALU_SLT;
        nxt.alu_in2     = sext;
        nxt.dest_reg    = bus.rt;
        nxt.reg_write   = 1'b1;
      end
      6'b000100: begin
        nxt.alu_control = ALU_SUB;
        nxt.alu_in2     = bus.rt_data;
        nxt.branch      = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Writes to register 0 are architecturally discarded
    if (nxt.dest_reg == '0) nxt.reg_write = 1'b0;
    nxt_ill = bus.id_valid && !legal;
    if (!bus.id_valid || !legal) nxt = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= '0;
      ill_q <= 1'b0;
    end else if (bus.flush) begin
      q     <= '0;
      ill_q <= 1'b0;
    end else if (bus.stall) begin
      ill_q <= 1'b0;
    end else begin
      q     <= nxt;
      ill_q <= nxt_ill;
    end
  end

  assign bus.ex_valid    = q.ex_valid;
  assign bus.alu_control = q.alu_control;
  assign bus.alu_in1     = q.alu_in1;
  assign bus.alu_in2     = q.alu_in2;
  assign bus.store_data  = q.store_data;
  assign bus.dest_reg    = q.dest_reg;
  assign bus.reg_write   = q.reg_write;
  assign bus.mem_read    = q.mem_read;
  assign bus.mem_write   = q.mem_write;
  assign bus.mem_to_reg  = q.mem_to_reg;
  assign bus.branch      = q.branch;
  assign bus.illegal     = ill_q;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the execute-stage ALU.
- Captures decoded register operands and the immediate, and translates opcode/funct into the 4-bit ALU control code.
- Presents registered operands and control to the ALU plus the control bits later stages need.
- Supports stall (hold), flush (bubble insertion) and illegal-instruction detection.

Parameters:
- WIDTH, 32, datapath width of operands and store data.
- REGBITS, 5, register index width.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage presents a valid instruction this cycle.
- stall  in  1  hold all outputs unchanged.
- flush  in  1  replace next stage contents with a bubble.
- opcode  in  6  instruction bits 31:26.
- funct  in  6  instruction bits 5:0.
- rs_data  in  WIDTH  register file read port A.
- rt_data  in  WIDTH  register file read port B.
- imm  in  16  instruction bits 15:0.
- rt  in  REGBITS  instruction bits 20:16.
- rd  in  REGBITS  instruction bits 15:11.
- ex_valid  out  1  registered instruction is valid.
- alu_control  out  4  0010 add, 0110 sub, 0111 slt, 0000 none.
- alu_in1  out  WIDTH  ALU operand 1.
- alu_in2  out  WIDTH  ALU operand 2.
- store_data  out  WIDTH  rt_data for stores.
- dest_reg  out  REGBITS  write-back register index.
- reg_write, mem_read, mem_write, mem_to_reg, branch  out  1 each  downstream controls.
- illegal  out  1  one-cycle pulse: an unsupported instruction was dropped.

Behaviour:
- Reset: every output is 0 on the first edge with reset=1.
- Update priority per edge: reset > flush > stall > load.
- Flush: load a bubble regardless of stall. A bubble is every output 0, including data outputs. illegal=0.
- Stall (without flush): every output holds, except illegal, which clears to 0.
- Load with id_valid=0: load a bubble.
- Load with id_valid=1: decode the instruction and register the result; latency is one cycle. Common fields for every decoded instruction:
  - alu_in1 = rs_data.
  - sext = imm sign-extended to WIDTH.
  - ex_valid = 1.
- Decode table (unlisted controls are 0):
  - opcode 000000, funct 100000 or 100001: alu_control 0010, alu_in2 = rt_data, dest_reg = rd, reg_write.
  - opcode 000000, funct 100010 or 100011: alu_control 0110, otherwise as the previous R-type.
  - opcode 000000, funct 101010: alu_control 0111, otherwise as the previous R-type.
  - 100011 lw: 0010, alu_in2 = sext, dest_reg = rt, reg_write, mem_read, mem_to_reg.
  - 101011 sw: 0010, alu_in2 = sext, store_data = rt_data, mem_write.
  - 001000 addi: 0010, alu_in2 = sext, dest_reg = rt, reg_write.
  - 001010 slti: 0111, alu_in2 = sext, dest_reg = rt, reg_write.
  - 000100 beq: 0110, alu_in2 = rt_data, branch. The ALU zero output drives the branch decision.
- store_data = rt_data for every decoded instruction; it is only meaningful for sw.
- dest_reg = 0 forces reg_write = 0. dest_reg is still registered.
- Any other opcode, or an R-type with another funct: load a bubble and set illegal = 1 for one cycle.
- Simultaneous stall and flush: flush wins.
- Reset asserted mid-stall: outputs clear.
- The block has no internal state beyond its output registers. Behaviour is deterministic from the inputs.

Test Plan:
- Reset: hold reset 2 cycles with id_valid=1 and an add presented -> all outputs 0. Release reset -> next edge loads the add.
- add $3,$1,$2: opcode 0, funct 100000, rd=3, rs_data=7, rt_data=5 -> after 1 edge: alu_control=0010, in1=7, in2=5, dest=3, reg_write=1, ex_valid=1.
- lw $4,-4($1): imm=FFFC, rs_data=100 -> in2=FFFFFFFC, alu_control=0010, mem_read=mem_to_reg=reg_write=1, dest=4. Same lw with rt=0 -> reg_write=0.
- Stall then flush:
  - Load slti (imm=0005).
  - Assert stall 3 cycles while inputs change to a beq -> outputs stay slti (0111, in2=5).
  - Assert stall and flush together -> all outputs 0.
- Illegal: opcode 000010 -> bubble, illegal=1 for exactly one cycle. A following sw (imm=0008, rt_data=AB) loads normally: illegal=0, mem_write=1, store_data=AB, in2=8.
- beq: rs_data=rt_data=9 -> alu_control=0110, branch=1, reg_write=0. A downstream ALU model yields zero=1.
